serial_divisibility_encoder: RTL and testbench



---
 rtl/serial_div_pkg.sv | 26 ++
 rtl/serial_mod_tracker.sv | 26 ++
 rtl/serial_divisibility_encoder.sv | 125 ++++++++++++
 tb/tb_serial_divisibility_encoder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_div_pkg.sv
// Shared types and arithmetic helpers for the serial divisibility encoder and checkers.
package serial_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2
  } state_t;

  // Remainder after appending one more bit (MSB-first) to a number whose remainder is rem.
  function automatic logic [7:0] next_rem(input logic [7:0] rem, input logic bit_in,
                                          input logic [7:0] modulus);
    logic [7:0] t;
    t = {rem[6:0], 1'b0} + {7'b0, bit_in};
    return t % modulus;
  endfunction

  // Smallest value that, appended as check_w bits, makes the whole number divisible.
  function automatic logic [7:0] check_value(input logic [7:0] rem, input logic [7:0] modulus,
                                             input int check_w);
    logic [7:0] scaled;
    scaled = (rem << check_w) % modulus;
    return (modulus - scaled) % modulus;
  endfunction

endpackage

// File: rtl/serial_mod_tracker.sv
// Running remainder of an MSB-first bit stream modulo MODULUS.
module serial_mod_tracker
  import serial_div_pkg::*;
#(
  parameter int MODULUS = 5,
  parameter int REM_W   = $clog2(MODULUS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [REM_W-1:0] rem
);

  logic [REM_W-1:0] rem_next;

  assign rem_next = REM_W'(next_rem(8'(rem), bit_in, 8'(MODULUS)));

  // clear wins over enable so a new frame always starts from zero
  always_ff @(posedge clk) begin
    if (rst || clr) rem <= '0;
    else if (en)    rem <= rem_next;
  end

endmodule

// File: rtl/serial_divisibility_encoder.sv
// Serialises a W-bit word MSB first and appends CHECK_W check bits so the frame
// is divisible by MODULUS.
//
// state | meaning
// IDLE  | waiting for a word, in_ready high
// DATA  | shifting out the W data bits
// CHECK | shifting out the CHECK_W check bits, out_last on the final one
module serial_divisibility_encoder
  import serial_div_pkg::*;
#(
  parameter int W       = 8,
  parameter int MODULUS = 5,
  parameter int CHECK_W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_bit,
  output logic         out_last,
  output logic         out_is_check
);

  localparam int SR_W  = (W > CHECK_W) ? W : CHECK_W;
  localparam int CNT_W = $clog2(SR_W + 1);
  localparam int REM_W = $clog2(MODULUS);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(W - 1);
  localparam logic [CNT_W-1:0] CHECK_LAST = CNT_W'(CHECK_W - 1);

  if ((1 << CHECK_W) < MODULUS) begin : g_check_w_too_small
    $error("CHECK_W too small to hold every check value for MODULUS");
  end

  state_t             state, state_next;
  logic [SR_W-1:0]    sr;
  logic [CNT_W-1:0]   cnt;
  logic [REM_W-1:0]   rem;
  logic [CHECK_W-1:0] chk;
  logic               accept, xfer, data_xfer;

  assign xfer      = out_valid & out_ready;
  assign data_xfer = xfer && (state == DATA);

  // chk uses the remainder including the data bit being transferred right now,
  // so the first check bit follows the last data bit without a bubble
  assign chk = CHECK_W'(check_value(8'(next_rem(8'(rem), out_bit, 8'(MODULUS))),
                                    8'(MODULUS), CHECK_W));

  serial_mod_tracker #(.MODULUS(MODULUS), .REM_W(REM_W)) u_tracker (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .en     (data_xfer),
    .bit_in (out_bit),
    .rem    (rem)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // next state and handshake/serial outputs, all decoded from registered state
  always_comb begin
    state_next   = state;
    in_ready     = 1'b0;
    accept       = 1'b0;
    out_valid    = 1'b0;
    out_bit      = 1'b0;
    out_last     = 1'b0;
    out_is_check = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = DATA;
        end
      end
      DATA: begin
        out_valid = 1'b1;
        out_bit   = sr[W-1];
        if (out_ready && cnt == DATA_LAST) state_next = CHECK;
      end
      CHECK: begin
        out_valid    = 1'b1;
        out_is_check = 1'b1;
        out_bit      = sr[CHECK_W-1];
        out_last     = (cnt == CHECK_LAST);
        if (out_ready && out_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // shift register and per-phase bit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (accept) begin
      sr  <= SR_W'(in_data);
      cnt <= '0;
    end else if (xfer) begin
      if (state == DATA && cnt == DATA_LAST) begin
        sr  <= SR_W'(chk);
        cnt <= '0;
      end else begin
        sr  <= sr << 1;
        cnt <= cnt + 1'b1;
      end
    end
  end

  // protocol sanity
  a_valid_state: assert property (@(posedge clk) disable iff (rst)
                                  out_valid == (state != IDLE));
  a_last_check:  assert property (@(posedge clk) disable iff (rst)
                                  out_last |-> out_is_check);

endmodule

// File: tb/tb_serial_divisibility_encoder.sv
// Bench for serial_divisibility_encoder: M=5/CHECK_W=3 main instance plus an
// M=3/CHECK_W=2 instance driven by the same stimulus.
module tb_serial_divisibility_encoder;

  localparam int W   = 8;
  localparam int M   = 5;
  localparam int CW  = 3;
  localparam int M3  = 3;
  localparam int CW3 = 2;
  localparam int FL  = W + CW;
  localparam int FL3 = W + CW3;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_bit;
  logic         out_last;
  logic         out_is_check;
  logic         in_ready3, out_valid3, out_bit3, out_last3, out_is_check3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_divisibility_encoder #(.W(W), .MODULUS(M), .CHECK_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_bit      (out_bit),
    .out_last     (out_last),
    .out_is_check (out_is_check)
  );

  serial_divisibility_encoder #(.W(W), .MODULUS(M3), .CHECK_W(CW3)) dut3 (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready3),
    .in_data      (in_data),
    .out_valid    (out_valid3),
    .out_ready    (out_ready),
    .out_bit      (out_bit3),
    .out_last     (out_last3),
    .out_is_check (out_is_check3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // frame value = data followed by the smallest check value that makes it divisible
  function automatic int ref_frame(input int data, input int m, input int cw);
    int base;
    base = data * (1 << cw);
    for (int c = 0; c < (1 << cw); c++)
      if ((base + c) % m == 0) return base + c;
    return -1;
  endfunction

  // Starts and ends at a negedge; stalls stall_len cycles before bits stall_a and stall_b.
  task automatic send_frame(input logic [W-1:0] data, input int stall_a, input int stall_b,
                            input int stall_len);
    int   frame, frame3;
    logic hb, hl, hc;
    bit   chk3;
    frame  = 0;
    frame3 = 0;
    chk3   = (stall_len == 0);
    check_eq("idle_in_ready", in_ready, 1);
    in_valid  = 1'b1;
    in_data   = data;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = W'($urandom);
    for (int i = 0; i < FL; i++) begin
      check_eq("out_valid", out_valid, 1);
      check_eq("busy_in_ready", in_ready, 0);
      if (stall_len > 0 && (i == stall_a || i == stall_b)) begin
        hb = out_bit;
        hl = out_last;
        hc = out_is_check;
        out_ready = 1'b0;
        repeat (stall_len) begin
          in_data = W'($urandom);
          @(negedge clk);
          check_eq("stall_valid", out_valid, 1);
          check_eq("stall_bit", out_bit, hb);
          check_eq("stall_last", out_last, hl);
          check_eq("stall_is_check", out_is_check, hc);
        end
        out_ready = 1'b1;
      end
      check_eq("is_check", out_is_check, i >= W);
      check_eq("last", out_last, i == FL - 1);
      frame = (frame << 1) | int'(out_bit);
      if (chk3 && i < FL3) begin
        frame3 = (frame3 << 1) | int'(out_bit3);
        check_eq("last3", out_last3, i == FL3 - 1);
        check_eq("is_check3", out_is_check3, i >= W);
      end
      @(negedge clk);
    end
    check_eq("frame", frame, ref_frame(int'(data), M, CW));
    check_eq("frame_div", frame % M, 0);
    if (chk3) check_eq("frame3", frame3, ref_frame(int'(data), M3, CW3));
    check_eq("done_valid", out_valid, 0);
    check_eq("done_in_ready", in_ready, 1);
  endtask

  int         acc_t[$];
  int         acc_d[$];
  int         got_f[$];
  int         fr;
  logic [7:0] ctr;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_bit", out_bit, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_is_check", out_is_check, 0);
    check_eq("rst_in_ready3", in_ready3, 1);

    // directed words
    send_frame(8'h01, -1, -1, 0);
    send_frame(8'h07, -1, -1, 0);
    send_frame(8'hA5, -1, -1, 0);
    send_frame(8'hFF, -1, -1, 0);
    send_frame(8'h00, -1, -1, 0);

    // backpressure at data bit 4 and check bit 1
    send_frame(8'h07, 4, 9, 3);
    send_frame(8'h01, 4, 9, 3);

    // random words with random stalls
    repeat (24) begin
      send_frame(W'($urandom), int'($urandom_range(0, FL - 1)),
                 int'($urandom_range(0, FL - 1)), int'($urandom_range(0, 3)));
    end

    // reset in the middle of a frame
    in_valid  = 1'b1;
    in_data   = 8'h5C;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_in_ready", in_ready, 1);
    check_eq("midrst_out_bit", out_bit, 0);
    check_eq("midrst_out_last", out_last, 0);
    check_eq("midrst_is_check", out_is_check, 0);
    @(negedge clk);
    check_eq("midrst_no_partial", out_valid, 0);
    send_frame(8'h3B, -1, -1, 0);

    // in_valid held high with data changing every cycle
    fr  = 0;
    ctr = 8'h30;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < FL * 6 + 6; cyc++) begin
      if (out_valid) begin
        fr = (fr << 1) | int'(out_bit);
        if (out_last) begin
          got_f.push_back(fr);
          fr = 0;
        end
      end
      in_valid = 1'b1;
      in_data  = ctr;
      ctr      = ctr + 8'd1;
      if (in_ready) begin
        acc_d.push_back(int'(in_data));
        acc_t.push_back(cyc);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check_eq("stream_accepts", acc_d.size(), 6);
    check_eq("stream_frames", got_f.size(), acc_d.size());
    for (int k = 1; k < acc_t.size(); k++)
      check_eq("stream_period", acc_t[k] - acc_t[k-1], FL + 1);
    for (int k = 0; k < got_f.size() && k < acc_d.size(); k++)
      check_eq("stream_frame", got_f[k], ref_frame(acc_d[k], M, CW));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
